// File: rtl/vector_mem_responder.sv
// Purpose: serialises one R-lane vector load/store onto a byte-wide synchronous RAM.
// Latency: store stalls R+1 cycles (DONE at R+1), load stalls R+2 cycles (DONE at R+2).
// Backpressure: StallM freezes the pipeline; request inputs must stay stable while it is high.
module vector_mem_responder #(
   parameter int I = 32,
   parameter int N = 8,
   parameter int R = 6,
   parameter int A = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           MemWriteM,
   input  logic           MemReadM,
   input  logic [I-1:0]   AddressM,
   input  logic [R*N-1:0] WriteDataM,
   output logic           StallM,
   output logic [R*N-1:0] ReadData,
   output logic [A-1:0]   ram_addr,
   output logic [N-1:0]   ram_wdata,
   output logic           ram_we,
   input  logic [N-1:0]   ram_rdata
);

   localparam int KW = (R > 1) ? $clog2(R) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(R - 1);

   typedef enum logic [2:0] {IDLE, WRITE, READ, RTAIL, DONE} state_t;

   state_t         state;
   logic [KW-1:0]  k;
   logic [R*N-1:0] wdata;
   logic           req;

   // Upper address bits select nothing in this RAM.
   logic [I-A-1:0] addr_hi_unused;
   assign addr_hi_unused = AddressM[I-1:A];

   assign req = MemWriteM | MemReadM;

   // Stall is combinational so a new request freezes the pipe in its very first cycle;
   // it is forced low while reset is held so an abort releases the pipeline at once.
   assign StallM = reset & (((state == IDLE) & req) | (state == WRITE) |
                            (state == READ) | (state == RTAIL));

   // Single FSM: ram_addr doubles as the running lane address (base+k), so the
   // base is captured directly into it and incremented modulo 2^A each lane.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         k         <= '0;
         wdata     <= '0;
         ReadData  <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  k        <= '0;
                  wdata    <= WriteDataM;
                  ram_addr <= AddressM[A-1:0];
                  // A combined read+write is treated purely as a store.
                  if (MemWriteM) begin
                     state     <= WRITE;
                     ram_we    <= 1'b1;
                     ram_wdata <= WriteDataM[N-1:0];
                  end else begin
                     state     <= READ;
                     ram_we    <= 1'b0;
                     ram_wdata <= '0;
                  end
               end
            end
            WRITE: begin
               if (k == K_LAST) begin
                  state     <= DONE;
                  ram_we    <= 1'b0;
                  ram_addr  <= '0;
                  ram_wdata <= '0;
               end else begin
                  k         <= k + KW'(1);
                  ram_addr  <= ram_addr + A'(1);
                  ram_wdata <= wdata[(int'(k) + 1) * N +: N];
               end
            end
            READ: begin
               // RAM data lags the address by one cycle, so lane k-1 lands now.
               if (k != '0) begin
                  ReadData[(int'(k) - 1) * N +: N] <= ram_rdata;
               end
               if (k == K_LAST) begin
                  state    <= RTAIL;
                  ram_addr <= '0;
               end else begin
                  k        <= k + KW'(1);
                  ram_addr <= ram_addr + A'(1);
               end
            end
            RTAIL: begin
               ReadData[(R-1) * N +: N] <= ram_rdata;
               state <= DONE;
            end
            DONE: begin
               // Pipeline advances this cycle; any request seen here is the next one.
               state <= IDLE;
               k     <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
